// File: rtl/pulse_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pulse_gen_pkg : shared states, mode codes and bin-to-Gray helper     |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
package pulse_gen_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   // Widest Gray count supported by the helper; callers truncate.
   localparam int GRAY_MAX_W = 16;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_gen_prog_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pulse_gen_prog_if : control/config inputs and pulse status outputs   |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
interface pulse_gen_prog_if #(
   parameter int CNT_W  = 27,
   parameter int GRAY_W = 4
);
   logic              en;
   logic              mode;
   logic              start;
   logic              load;
   logic [CNT_W-1:0]  period;
   logic [CNT_W-1:0]  width;
   logic              pulse;
   logic              busy;
   logic              cfg_err;
   logic [GRAY_W-1:0] pulse_cnt_gray;

   modport master (
      output en, mode, start, load, period, width,
      input  pulse, busy, cfg_err, pulse_cnt_gray
   );

   modport slave (
      input  en, mode, start, load, period, width,
      output pulse, busy, cfg_err, pulse_cnt_gray
   );
endinterface
`default_nettype wire

// File: rtl/gray_counter_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gray_counter_n : enabled binary counter with registered Gray output  |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module gray_counter_n
   import pulse_gen_pkg::*;
#(
   parameter int GRAY_W = 4
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              en,
   output logic      [GRAY_W-1:0] gray
);

   logic [GRAY_W-1:0] bin_q, bin_d;
   logic [GRAY_W-1:0] gray_q, gray_d;

   // Gray is derived from the next binary value so both update on the same edge.
   always_comb begin
      bin_d  = en ? bin_q + GRAY_W'(1) : bin_q;
      gray_d = GRAY_W'(bin2gray(GRAY_MAX_W'(bin_d)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
      end
   end

   assign gray = gray_q;

endmodule
`default_nettype wire

// File: rtl/pulse_gen_prog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pulse_gen_prog : programmable periodic / one-shot pulse generator    |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module pulse_gen_prog
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W      = 27,
   parameter int DEF_PERIOD = 100_000_000,
   parameter int DEF_WIDTH  = 1,
   parameter int GRAY_W     = 4
) (
   input  wire logic   clk,
   input  wire logic   rst,
   pulse_gen_prog_if.slave bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] shadow_p_q, shadow_p_d;
   logic [CNT_W-1:0] shadow_w_q, shadow_w_d;
   logic [CNT_W-1:0] act_p_q, act_p_d;
   logic [CNT_W-1:0] act_w_q, act_w_d;
   logic             mode_q, mode_d;
   logic             cfg_err_q, cfg_err_d;
   logic             pulse_q, pulse_d;
   logic             busy_q, busy_d;
   logic             gray_inc;

   logic [CNT_W-1:0] p_eff;
   logic             p_clamp;
   logic             w_clamp;

   // Load path: clamp the request and stage it in the shadow registers.
   always_comb begin
      p_clamp    = bus.period < CNT_W'(2);
      p_eff      = p_clamp ? CNT_W'(2) : bus.period;
      w_clamp    = bus.width >= p_eff;
      shadow_p_d = shadow_p_q;
      shadow_w_d = shadow_w_q;
      cfg_err_d  = cfg_err_q;
      if (bus.load) begin
         shadow_p_d = p_eff;
         shadow_w_d = w_clamp ? p_eff - CNT_W'(1) : bus.width;
         cfg_err_d  = p_clamp | w_clamp;
      end
   end

   // Shadow values are taken from the _d side so a load on a boundary lands at once.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_p_d = act_p_q;
      act_w_d = act_w_q;
      mode_d  = mode_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d   = '0;
            act_p_d = shadow_p_d;
            act_w_d = shadow_w_d;
            if (bus.en && (bus.mode == MODE_PERIODIC || bus.start)) begin
               state_d = ST_RUN;
               mode_d  = bus.mode;
            end
         end
         ST_RUN: begin
            if (!bus.en) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == act_p_q - CNT_W'(1)) begin
               cnt_d = '0;
               if (mode_q == MODE_ONESHOT) begin
                  state_d = ST_IDLE;
               end else begin
                  act_p_d = shadow_p_d;
                  act_w_d = shadow_w_d;
                  mode_d  = bus.mode;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d   = (state_d == ST_RUN);
      pulse_d  = busy_d && (cnt_d < act_w_d);
      gray_inc = busy_d && (cnt_d == '0) && (act_w_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shadow_p_q <= CNT_W'(DEF_PERIOD);
         shadow_w_q <= CNT_W'(DEF_WIDTH);
         act_p_q    <= CNT_W'(DEF_PERIOD);
         act_w_q    <= CNT_W'(DEF_WIDTH);
         mode_q     <= MODE_PERIODIC;
         cfg_err_q  <= 1'b0;
         pulse_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shadow_p_q <= shadow_p_d;
         shadow_w_q <= shadow_w_d;
         act_p_q    <= act_p_d;
         act_w_q    <= act_w_d;
         mode_q     <= mode_d;
         cfg_err_q  <= cfg_err_d;
         pulse_q    <= pulse_d;
         busy_q     <= busy_d;
      end
   end

   gray_counter_n #(
      .GRAY_W (GRAY_W)
   ) u_gray (
      .clk  (clk),
      .rst  (rst),
      .en   (gray_inc),
      .gray (bus.pulse_cnt_gray)
   );

   assign bus.pulse   = pulse_q;
   assign bus.busy    = busy_q;
   assign bus.cfg_err = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen_prog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pulse_gen_prog : directed vector bench for pulse_gen_prog         |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module tb_pulse_gen_prog;

   localparam int CNT_W      = 8;
   localparam int DEF_PERIOD = 10;
   localparam int DEF_WIDTH  = 1;
   localparam int GRAY_W     = 3;

   typedef struct {
      logic       en;
      logic       mode;
      logic       start;
      logic       load;
      logic [7:0] per;
      logic [7:0] wid;
      logic       e_pulse;
      logic       e_busy;
      logic       e_err;
      logic [2:0] e_gray;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t tbl[$];
   logic [2:0] gray_prev;
   logic [2:0] seq_a [8];

   pulse_gen_prog_if #(.CNT_W(CNT_W), .GRAY_W(GRAY_W)) bus ();

   pulse_gen_prog #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_WIDTH  (DEF_WIDTH),
      .GRAY_W     (GRAY_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input int n, input logic en, input logic mode, input logic start,
                      input logic load, input int per, input int wid,
                      input logic p, input logic b, input logic e, input int g);
      vec_t v;
      v.en = en; v.mode = mode; v.start = start; v.load = load;
      v.per = 8'(per); v.wid = 8'(wid);
      v.e_pulse = p; v.e_busy = b; v.e_err = e; v.e_gray = 3'(g);
      for (int k = 0; k < n; k++) tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every change of the Gray output outside reset must flip exactly one bit.
   always @(negedge clk) begin
      if (rst) begin
         gray_prev = '0;
      end else if (bus.pulse_cnt_gray !== gray_prev) begin
         chk("gray_one_bit", 32'($countones(bus.pulse_cnt_gray ^ gray_prev)), 32'd1);
         gray_prev = bus.pulse_cnt_gray;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      seq_a[0] = 3'd1; seq_a[1] = 3'd3; seq_a[2] = 3'd2; seq_a[3] = 3'd6;
      seq_a[4] = 3'd7; seq_a[5] = 3'd5; seq_a[6] = 3'd4; seq_a[7] = 3'd0;

      // Load 5/2 mid-period: current 10-cycle period finishes first.
      add(1, 1,0,0,0, 0,0,   1,1,0,1);
      add(2, 1,0,0,0, 0,0,   0,1,0,1);
      add(1, 1,0,0,1, 5,2,   0,1,0,1);
      add(6, 1,0,0,0, 0,0,   0,1,0,1);
      add(2, 1,0,0,0, 0,0,   1,1,0,3);
      add(3, 1,0,0,0, 0,0,   0,1,0,3);
      add(2, 1,0,0,0, 0,0,   1,1,0,2);
      add(3, 1,0,0,0, 0,0,   0,1,0,2);
      add(1, 1,0,0,0, 0,0,   1,1,0,6);
      // Clamped load 1/7 -> 2/1 with cfg_err, then clean load 6/3.
      add(1, 1,0,0,1, 1,7,   1,1,1,6);
      add(3, 1,0,0,0, 0,0,   0,1,1,6);
      add(1, 1,0,0,0, 0,0,   1,1,1,7);
      add(1, 1,0,0,0, 0,0,   0,1,1,7);
      add(1, 1,0,0,0, 0,0,   1,1,1,5);
      add(1, 1,0,0,0, 0,0,   0,1,1,5);
      add(1, 1,0,0,0, 0,0,   1,1,1,4);
      add(1, 1,0,0,1, 6,3,   0,1,0,4);
      add(3, 1,0,0,0, 0,0,   1,1,0,0);
      add(3, 1,0,0,0, 0,0,   0,1,0,0);
      add(1, 1,0,0,0, 0,0,   1,1,0,1);
      // Abort with a 10/1 load, then one-shots; a start while busy is ignored.
      add(1, 0,0,0,1, 10,1,  0,0,0,1);
      add(1, 1,1,0,0, 0,0,   0,0,0,1);
      add(1, 1,1,1,0, 0,0,   1,1,0,3);
      add(1, 1,1,0,0, 0,0,   0,1,0,3);
      add(1, 1,1,1,0, 0,0,   0,1,0,3);
      add(7, 1,1,0,0, 0,0,   0,1,0,3);
      add(2, 1,1,0,0, 0,0,   0,0,0,3);
      add(1, 1,1,1,0, 0,0,   1,1,0,2);
      add(9, 1,1,0,0, 0,0,   0,1,0,2);
      add(1, 1,1,0,0, 0,0,   0,0,0,2);
      add(1, 0,1,1,0, 0,0,   0,0,0,2);
      // Width 4: drop en at cnt=2, re-enable for a full-width first pulse.
      add(1, 0,0,0,1, 10,4,  0,0,0,2);
      add(1, 1,0,0,0, 0,0,   1,1,0,6);
      add(2, 1,0,0,0, 0,0,   1,1,0,6);
      add(1, 0,0,0,0, 0,0,   0,0,0,6);
      add(1, 1,0,0,0, 0,0,   1,1,0,7);
      add(3, 1,0,0,0, 0,0,   1,1,0,7);
      add(1, 1,0,0,0, 0,0,   0,1,0,7);

      rst = 1'b1;
      bus.en = 1'b0; bus.mode = 1'b0; bus.start = 1'b0; bus.load = 1'b0;
      bus.period = '0; bus.width = '0;
      tick();
      tick();
      chk("reset_pulse", 32'(bus.pulse), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_err", 32'(bus.cfg_err), 32'd0);
      chk("reset_gray", 32'(bus.pulse_cnt_gray), 32'd0);
      rst = 1'b0;

      // Default 10/1 periodic run through a full Gray wrap.
      bus.en = 1'b1;
      for (int i = 0; i < 80; i++) begin
         tick();
         chk("per_pulse", 32'(bus.pulse), 32'((i % 10) == 0));
         chk("per_busy", 32'(bus.busy), 32'd1);
         chk("per_gray", 32'(bus.pulse_cnt_gray), 32'(seq_a[i / 10]));
      end

      foreach (tbl[i]) begin
         bus.en     = tbl[i].en;
         bus.mode   = tbl[i].mode;
         bus.start  = tbl[i].start;
         bus.load   = tbl[i].load;
         bus.period = tbl[i].per;
         bus.width  = tbl[i].wid;
         tick();
         chk($sformatf("vec%0d_pulse", i), 32'(bus.pulse), 32'(tbl[i].e_pulse));
         chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].e_busy));
         chk($sformatf("vec%0d_err", i), 32'(bus.cfg_err), 32'(tbl[i].e_err));
         chk($sformatf("vec%0d_gray", i), 32'(bus.pulse_cnt_gray), 32'(tbl[i].e_gray));
      end
      bus.load = 1'b0; bus.start = 1'b0;

      // Asynchronous reset in the middle of a high pulse.
      for (int k = 0; k < 20 && bus.pulse !== 1'b1; k++) tick();
      chk("rst_wait_pulse", 32'(bus.pulse), 32'd1);
      #3 rst = 1'b1;
      #1;
      chk("arst_pulse", 32'(bus.pulse), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_err", 32'(bus.cfg_err), 32'd0);
      chk("arst_gray", 32'(bus.pulse_cnt_gray), 32'd0);
      tick();
      tick();
      chk("arst_hold_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;

      // Config must be back to 10/1.
      for (int i = 0; i < 11; i++) begin
         tick();
         chk("post_rst_pulse", 32'(bus.pulse), 32'(i == 0 || i == 10));
         chk("post_rst_busy", 32'(bus.busy), 32'd1);
         chk("post_rst_gray", 32'(bus.pulse_cnt_gray), (i < 10) ? 32'd1 : 32'd3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
